// File: rtl/arbitro_divisor.sv
// Round-robin arbiter sharing one sequential divider among NREQ requesters, with divide-by-zero and hang traps.
// Latency: acepte to listo is D+3 cycles minimum for a D-cycle divider; a zero divisor gives listo one cycle after acepte.
// Backpressure: requesters hold sol until acepte; only one job is in flight and new grants are made only in INACTIVO.
module arbitro_divisor #(
    parameter int NREQ       = 4,
    parameter int DD_W       = 32,
    parameter int DV_W       = 16,
    parameter int Q_W        = 32,
    parameter int MAX_CICLOS = 255
) (
    input  logic                 reloj,
    input  logic                 reset,
    input  logic [NREQ-1:0]      sol,
    input  logic [NREQ*DD_W-1:0] dividendo_in,
    input  logic [NREQ*DV_W-1:0] divisor_in,
    output logic [NREQ-1:0]      acepte,
    output logic [NREQ-1:0]      listo,
    output logic [Q_W-1:0]       cociente_out,
    output logic                 error,
    output logic                 ocupado,
    output logic [DD_W-1:0]      div_dividendo,
    output logic [DV_W-1:0]      div_divisor,
    output logic                 div_inicie,
    input  logic                 div_termino,
    input  logic [Q_W-1:0]       div_cociente
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WD_W  = $clog2(MAX_CICLOS + 1);
    localparam logic [NREQ-1:0] UNO = NREQ'(1);

    typedef enum logic [2:0] {
        ESPERA_LISTO,
        INACTIVO,
        ARRANQUE,
        CALCULO,
        ENTREGA
    } estado_t;

    estado_t          estado_q, estado_d;
    logic [IDX_W-1:0] rr_q, rr_d, sel_q, sel_d;
    logic [WD_W-1:0]  wd_q, wd_d, wd_inc;
    logic [NREQ-1:0]  acepte_q, acepte_d, listo_q, listo_d;
    logic [Q_W-1:0]   cociente_q, cociente_d;
    logic             error_q, error_d, ocupado_q, ocupado_d, inicie_q, inicie_d;
    logic [DD_W-1:0]  dividendo_q, dividendo_d;
    logic [DV_W-1:0]  divisor_q, divisor_d;
    logic             hallado;
    int               idx, cand;

    always_comb begin
        estado_d    = estado_q;
        rr_d        = rr_q;
        sel_d       = sel_q;
        wd_d        = wd_q;
        wd_inc      = wd_q + WD_W'(1);
        acepte_d    = '0;
        listo_d     = '0;
        cociente_d  = cociente_q;
        error_d     = error_q;
        inicie_d    = inicie_q;
        dividendo_d = dividendo_q;
        divisor_d   = divisor_q;
        hallado     = 1'b0;
        idx         = 0;
        cand        = 0;

        case (estado_q)
            ESPERA_LISTO: begin
                if (div_termino) estado_d = INACTIVO;
            end
            INACTIVO: begin
                // First pending request at or above the pointer, wrapping around.
                for (int i = 0; i < NREQ; i++) begin
                    cand = int'(rr_q) + i;
                    if (cand >= NREQ) cand = cand - NREQ;
                    if (!hallado && sol[cand]) begin
                        hallado = 1'b1;
                        idx     = cand;
                    end
                end
                if (hallado) begin
                    sel_d       = IDX_W'(idx);
                    rr_d        = (idx == NREQ - 1) ? '0 : IDX_W'(idx + 1);
                    acepte_d    = UNO << idx;
                    dividendo_d = dividendo_in[idx*DD_W +: DD_W];
                    divisor_d   = divisor_in[idx*DV_W +: DV_W];
                    if (divisor_in[idx*DV_W +: DV_W] == '0) begin
                        cociente_d = '1;
                        error_d    = 1'b1;
                        estado_d   = ENTREGA;
                    end else begin
                        inicie_d = 1'b1;
                        wd_d     = '0;
                        estado_d = ARRANQUE;
                    end
                end
            end
            ARRANQUE, CALCULO: begin
                if (estado_q == ARRANQUE && !div_termino) begin
                    inicie_d = 1'b0;
                    wd_d     = '0;
                    estado_d = CALCULO;
                end else if (estado_q == CALCULO && div_termino) begin
                    cociente_d = div_cociente;
                    error_d    = 1'b0;
                    estado_d   = ENTREGA;
                end else if (wd_inc == WD_W'(MAX_CICLOS)) begin
                    // Divider is stuck: report the abort directly and resync on its idle flag.
                    inicie_d   = 1'b0;
                    cociente_d = '1;
                    error_d    = 1'b1;
                    listo_d    = UNO << sel_q;
                    estado_d   = ESPERA_LISTO;
                end else begin
                    wd_d = wd_inc;
                end
            end
            ENTREGA: begin
                listo_d  = UNO << sel_q;
                estado_d = INACTIVO;
            end
            default: estado_d = ESPERA_LISTO;
        endcase

        ocupado_d = (estado_d != INACTIVO);
    end

    always_ff @(posedge reloj) begin
        if (reset) begin
            estado_q    <= ESPERA_LISTO;
            rr_q        <= '0;
            sel_q       <= '0;
            wd_q        <= '0;
            acepte_q    <= '0;
            listo_q     <= '0;
            cociente_q  <= '0;
            error_q     <= 1'b0;
            ocupado_q   <= 1'b0;
            inicie_q    <= 1'b0;
            dividendo_q <= '0;
            divisor_q   <= '0;
        end else begin
            estado_q    <= estado_d;
            rr_q        <= rr_d;
            sel_q       <= sel_d;
            wd_q        <= wd_d;
            acepte_q    <= acepte_d;
            listo_q     <= listo_d;
            cociente_q  <= cociente_d;
            error_q     <= error_d;
            ocupado_q   <= ocupado_d;
            inicie_q    <= inicie_d;
            dividendo_q <= dividendo_d;
            divisor_q   <= divisor_d;
        end
    end

    assign acepte        = acepte_q;
    assign listo         = listo_q;
    assign cociente_out  = cociente_q;
    assign error         = error_q;
    assign ocupado       = ocupado_q;
    assign div_inicie    = inicie_q;
    assign div_dividendo = dividendo_q;
    assign div_divisor   = divisor_q;
endmodule

// File: tb/tb_arbitro_divisor.sv
// Directed bench for arbitro_divisor with a small sequential divider model that can hang or hold its busy flag.
module tb_arbitro_divisor;
    localparam int NREQ = 4;
    localparam int LAT  = 3;

    logic               reloj = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    sol;
    logic [NREQ*32-1:0] dividendo_in;
    logic [NREQ*16-1:0] divisor_in;
    logic [NREQ-1:0]    acepte, listo;
    logic [31:0]        cociente_out;
    logic               error, ocupado;
    logic [31:0]        div_dividendo;
    logic [15:0]        div_divisor;
    logic               div_inicie;
    logic               div_termino = 1'b1;
    logic [31:0]        div_cociente = '0;

    logic colgar      = 1'b0;
    logic forzar_bajo = 1'b0;
    logic m_ocup      = 1'b0;
    int   m_cnt       = 0;

    int n_tests = 0;
    int n_fail  = 0;

    arbitro_divisor #(.NREQ(NREQ), .DD_W(32), .DV_W(16), .Q_W(32), .MAX_CICLOS(255)) dut (
        .reloj(reloj), .reset(reset), .sol(sol),
        .dividendo_in(dividendo_in), .divisor_in(divisor_in),
        .acepte(acepte), .listo(listo), .cociente_out(cociente_out),
        .error(error), .ocupado(ocupado),
        .div_dividendo(div_dividendo), .div_divisor(div_divisor),
        .div_inicie(div_inicie), .div_termino(div_termino), .div_cociente(div_cociente)
    );

    always #5 reloj = ~reloj;

    // Divider model: drops termino the edge after seeing inicie, raises it LAT+1 edges later.
    always @(posedge reloj) begin
        if (forzar_bajo) begin
            div_termino <= 1'b0;
            m_ocup      <= 1'b0;
        end else if (reset) begin
            div_termino <= 1'b1;
            m_ocup      <= 1'b0;
        end else if (colgar) begin
            div_termino <= 1'b1;
        end else if (m_ocup) begin
            if (m_cnt == 0) begin
                div_termino <= 1'b1;
                m_ocup      <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (div_inicie) begin
            div_termino  <= 1'b0;
            m_ocup       <= 1'b1;
            m_cnt        <= LAT;
            div_cociente <= div_dividendo / {16'h0, div_divisor};
        end else begin
            div_termino <= 1'b1;
        end
    end

    typedef struct {
        int          req;
        logic [31:0] dd;
        logic [15:0] dv;
        logic [31:0] q;
        logic        err;
    } vec_t;

    vec_t tabla [6];

    task automatic chk(input string nombre, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nombre, act, req);
        end
    endtask

    task automatic pedir(input int k, input logic [31:0] dd, input logic [15:0] dv);
        sol[k] = 1'b1;
        dividendo_in[k*32 +: 32] = dd;
        divisor_in[k*16 +: 16]   = dv;
    endtask

    task automatic esperar_acepte(input string nombre, output int c);
        c = 0;
        while (acepte == '0 && c < 600) begin
            @(negedge reloj);
            c++;
        end
        if (acepte == '0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no acepte within 600 cycles", nombre);
        end
    endtask

    task automatic esperar_listo(input string nombre, output int c, output int n_ac, output logic ini);
        c    = 0;
        n_ac = 0;
        ini  = div_inicie;
        while (listo == '0 && c < 600) begin
            @(negedge reloj);
            c++;
            if (acepte != '0) n_ac++;
            if (div_inicie) ini = 1'b1;
        end
        if (listo == '0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no listo within 600 cycles", nombre);
        end
    endtask

    task automatic pulso_reset();
        reset = 1'b1;
        repeat (2) @(negedge reloj);
        reset = 1'b0;
    endtask

    initial begin
        int          c, n_ac, ac_cnt, li_cnt;
        logic        ini;
        logic [3:0]  oh;
        int          orden [5];

        tabla[0] = '{0, 32'h352,      16'h3,   32'h11B,      1'b0};
        tabla[1] = '{1, 32'd1024,     16'h20,  32'd32,       1'b0};
        tabla[2] = '{2, 32'd100,      16'h0,   32'hFFFFFFFF, 1'b1};
        tabla[3] = '{3, 32'hFFFFFFFF, 16'h1,   32'hFFFFFFFF, 1'b0};
        tabla[4] = '{0, 32'd7,        16'h8,   32'd0,        1'b0};
        tabla[5] = '{1, 32'h12345678, 16'h100, 32'h123456,   1'b0};
        orden    = '{0, 1, 2, 3, 0};

        reset        = 1'b1;
        sol          = '0;
        dividendo_in = '0;
        divisor_in   = '0;
        repeat (3) @(negedge reloj);
        chk("reset acepte", acepte, 0);
        chk("reset listo", listo, 0);
        chk("reset cociente", cociente_out, 0);
        chk("reset error", error, 0);
        chk("reset ocupado", ocupado, 0);
        chk("reset inicie", div_inicie, 0);
        reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            @(negedge reloj);
            pedir(tabla[v].req, tabla[v].dd, tabla[v].dv);
            oh = 4'b0001 << tabla[v].req;
            esperar_acepte("vec acepte", c);
            chk("vec acepte onehot", acepte, oh);
            chk("vec div_dividendo", div_dividendo, tabla[v].dd);
            chk("vec div_divisor", div_divisor, tabla[v].dv);
            sol[tabla[v].req] = 1'b0;
            esperar_listo("vec listo", c, n_ac, ini);
            if (tabla[v].dv == 16'h0) begin
                chk("div0 listo latency", c, 1);
                chk("div0 inicie never", ini, 0);
            end
            chk("vec listo onehot", listo, oh);
            chk("vec cociente", cociente_out, tabla[v].q);
            chk("vec error", error, tabla[v].err);
            @(negedge reloj);
            chk("vec listo one cycle", listo, 0);
        end

        // Round robin with every requester held high.
        pulso_reset();
        for (int k = 0; k < NREQ; k++) pedir(k, 32'd100 * (k + 1), 16'(k + 1));
        for (int j = 0; j < 5; j++) begin
            oh = 4'b0001 << orden[j];
            esperar_acepte("rr acepte", c);
            chk("rr grant order", acepte, oh);
            chk("rr ocupado busy", ocupado, 1);
            if (j == 4) sol = '0;
            esperar_listo("rr listo", c, n_ac, ini);
            chk("rr single acepte", n_ac, 0);
            chk("rr listo onehot", listo, oh);
            chk("rr ocupado idle", ocupado, 0);
            chk("rr cociente", cociente_out, 100);
        end

        // Divider ignores the start request: watchdog aborts from ARRANQUE.
        @(negedge reloj);
        colgar = 1'b1;
        pedir(3, 32'd50, 16'd5);
        esperar_acepte("hang acepte", c);
        chk("hang acepte onehot", acepte, 4'b1000);
        sol = '0;
        esperar_listo("hang listo", c, n_ac, ini);
        chk("hang listo latency", c, 255);
        chk("hang listo onehot", listo, 4'b1000);
        chk("hang error", error, 1);
        chk("hang cociente", cociente_out, 32'hFFFFFFFF);
        chk("hang inicie low", div_inicie, 0);
        colgar = 1'b0;

        // Divider stays busy: abort from CALCULO, then no grant until termino returns.
        @(negedge reloj);
        forzar_bajo = 1'b1;
        pedir(2, 32'd40, 16'd4);
        esperar_acepte("busy acepte", c);
        chk("busy acepte onehot", acepte, 4'b0100);
        sol = '0;
        esperar_listo("busy listo", c, n_ac, ini);
        chk("busy listo latency", c, 256);
        chk("busy error", error, 1);
        pedir(0, 32'd9, 16'd3);
        ac_cnt = 0;
        repeat (10) begin
            @(negedge reloj);
            if (acepte != '0) ac_cnt++;
        end
        chk("busy no grant while termino low", ac_cnt, 0);
        forzar_bajo = 1'b0;
        esperar_acepte("busy resume acepte", c);
        chk("busy resume onehot", acepte, 4'b0001);
        sol = '0;
        esperar_listo("busy resume listo", c, n_ac, ini);
        chk("busy resume cociente", cociente_out, 3);
        chk("busy resume error", error, 0);

        // Reset while stuck in CALCULO, then held-off restart.
        @(negedge reloj);
        forzar_bajo = 1'b1;
        pedir(1, 32'd77, 16'd7);
        esperar_acepte("rst acepte", c);
        repeat (5) @(negedge reloj);
        reset = 1'b1;
        @(negedge reloj);
        chk("rst acepte", acepte, 0);
        chk("rst listo", listo, 0);
        chk("rst cociente", cociente_out, 0);
        chk("rst error", error, 0);
        chk("rst ocupado", ocupado, 0);
        chk("rst inicie", div_inicie, 0);
        chk("rst div_dividendo", div_dividendo, 0);
        chk("rst div_divisor", div_divisor, 0);
        @(negedge reloj);
        reset  = 1'b0;
        ac_cnt = 0;
        li_cnt = 0;
        repeat (5) begin
            @(negedge reloj);
            if (acepte != '0) ac_cnt++;
            if (listo != '0) li_cnt++;
        end
        chk("post-reset no acepte", ac_cnt, 0);
        chk("post-reset no listo", li_cnt, 0);
        forzar_bajo = 1'b0;
        esperar_acepte("post-reset acepte", c);
        chk("post-reset onehot", acepte, 4'b0010);
        sol = '0;
        esperar_listo("post-reset listo", c, n_ac, ini);
        chk("post-reset cociente", cociente_out, 11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
